// File: rtl/segre_mem_stage.sv
// MEM stage: registers EX results, runs load/store on the data-memory port and feeds MEM/WB.
// Optional SEGRE_MEM_MISALIGN_EN: misaligned HALF/WORD retire without a request and flag misalign_o.
//
// state | meaning
// IDLE  | no access in flight; issues request when a memory op is held in the input register
// WAIT  | load granted, waiting for rvalid
module segre_mem_stage #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32,
  parameter int REG_SIZE  = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_mem_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  logic [1:0]           memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
  input  logic                 is_jaljalr_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [3:0]           dmem_be_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 stall_o,
`ifdef SEGRE_MEM_MISALIGN_EN
  output logic                 misalign_o,
`endif
  output logic                 wb_valid_o,
  output logic                 wb_rf_we_o,
  output logic [REG_SIZE-1:0]  wb_rf_waddr_o,
  output logic [WORD_SIZE-1:0] wb_rf_wdata_o
);

  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} memop_data_type_e;
  typedef enum logic {IDLE, WAIT} state_e;

  state_e state_q, state_d;

  logic                 valid_q, rf_we_q, rd_q, wr_q, sign_ext_q, is_jaljalr_q;
  logic [WORD_SIZE-1:0] alu_res_q, st_data_q;
  logic [REG_SIZE-1:0]  rf_waddr_q;
  logic [1:0]           memop_type_q;
  logic [ADDR_SIZE-1:0] seq_new_pc_q;

  logic                 mem_op_q, access_c;
  logic                 req_c, retire_alu_c, retire_st_c, retire_ld_c;
  logic [1:0]           off;
  logic [3:0]           be_c;
  logic [WORD_SIZE-1:0] wdata_c, ld_data_c;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      alu_res_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      st_data_q    <= '0;
      memop_type_q <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      sign_ext_q   <= 1'b0;
      seq_new_pc_q <= '0;
      is_jaljalr_q <= 1'b0;
    end else if (!stall_o) begin
      valid_q      <= valid_mem_i;
      alu_res_q    <= alu_res_i;
      rf_we_q      <= rf_we_i;
      rf_waddr_q   <= rf_waddr_i;
      st_data_q    <= rf_st_data_i;
      memop_type_q <= memop_type_i;
      rd_q         <= memop_rd_i;
      wr_q         <= memop_wr_i;
      sign_ext_q   <= memop_sign_ext_i;
      seq_new_pc_q <= seq_new_pc_i;
      is_jaljalr_q <= is_jaljalr_i;
    end
  end

  assign mem_op_q = valid_q & (rd_q | wr_q);
  assign off      = alu_res_q[1:0];

`ifdef SEGRE_MEM_MISALIGN_EN
  logic misalign_c;
  assign misalign_c = mem_op_q & (((memop_type_q == HALF) & off[0]) |
                                  ((memop_type_q == WORD) & (off != 2'b00)));
  assign access_c   = mem_op_q & ~misalign_c;
`else
  assign access_c   = mem_op_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // A misaligned op (when trapped) takes the plain retire path without touching memory.
  always_comb begin
    state_d      = state_q;
    req_c        = 1'b0;
    retire_alu_c = 1'b0;
    retire_st_c  = 1'b0;
    retire_ld_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access_c) begin
          req_c = 1'b1;
          if (dmem_gnt_i) begin
            if (wr_q) retire_st_c = 1'b1;
            else      state_d     = WAIT;
          end
        end else begin
          retire_alu_c = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          retire_ld_c = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  assign stall_o = access_c & ~retire_st_c & ~retire_ld_c;

  always_comb begin
    be_c    = 4'b1111;
    wdata_c = st_data_q;
    case (memop_type_q)
      BYTE: begin
        be_c    = 4'b0001 << off;
        wdata_c = {4{st_data_q[7:0]}};
      end
      HALF: begin
        be_c    = 4'b0011 << {off[1], 1'b0};
        wdata_c = {2{st_data_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Address/strobe/data are zeroed whenever no request is presented.
  assign dmem_req_o   = req_c;
  assign dmem_we_o    = req_c & wr_q;
  assign dmem_addr_o  = req_c ? {alu_res_q[ADDR_SIZE-1:2], 2'b00} : '0;
  assign dmem_be_o    = req_c ? be_c : 4'b0000;
  assign dmem_wdata_o = req_c ? wdata_c : '0;

  always_comb begin
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    byte_v    = dmem_rdata_i[{off, 3'b000} +: 8];
    half_v    = dmem_rdata_i[{off[1], 4'b0000} +: 16];
    ld_data_c = dmem_rdata_i;
    case (memop_type_q)
      BYTE: ld_data_c = {{(WORD_SIZE-8){sign_ext_q & byte_v[7]}}, byte_v};
      HALF: ld_data_c = {{(WORD_SIZE-16){sign_ext_q & half_v[15]}}, half_v};
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_o    <= 1'b0;
      wb_rf_we_o    <= 1'b0;
      wb_rf_waddr_o <= '0;
      wb_rf_wdata_o <= '0;
`ifdef SEGRE_MEM_MISALIGN_EN
      misalign_o    <= 1'b0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      wb_rf_we_o <= 1'b0;
`ifdef SEGRE_MEM_MISALIGN_EN
      misalign_o <= misalign_c & (state_q == IDLE);
`endif
      if (retire_alu_c) begin
        wb_valid_o <= valid_q;
`ifdef SEGRE_MEM_MISALIGN_EN
        wb_rf_we_o <= rf_we_q & valid_q & ~misalign_c;
`else
        wb_rf_we_o <= rf_we_q & valid_q;
`endif
        if (valid_q) begin
          wb_rf_waddr_o <= rf_waddr_q;
          wb_rf_wdata_o <= is_jaljalr_q ? seq_new_pc_q : alu_res_q;
        end
      end else if (retire_st_c) begin
        wb_valid_o    <= 1'b1;
        wb_rf_waddr_o <= rf_waddr_q;
      end else if (retire_ld_c) begin
        wb_valid_o    <= 1'b1;
        wb_rf_we_o    <= rf_we_q;
        wb_rf_waddr_o <= rf_waddr_q;
        wb_rf_wdata_o <= ld_data_c;
      end
    end
  end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage: ALU/JAL retire, stores/loads with lane alignment,
// grant back-pressure, reset during an outstanding load, misaligned handling.
module tb_segre_mem_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_mem_i;
  logic [31:0] alu_res_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic [31:0] rf_st_data_i;
  logic [1:0]  memop_type_i;
  logic        memop_rd_i, memop_wr_i, memop_sign_ext_i;
  logic [31:0] seq_new_pc_i;
  logic        is_jaljalr_i;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        stall_o;
  logic        wb_valid_o, wb_rf_we_o;
  logic [4:0]  wb_rf_waddr_o;
  logic [31:0] wb_rf_wdata_o;
`ifdef SEGRE_MEM_MISALIGN_EN
  logic        misalign_o;
`endif

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  localparam logic [1:0] T_BYTE = 2'b00, T_HALF = 2'b01, T_WORD = 2'b10;

  segre_mem_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_mem_i(valid_mem_i), .alu_res_i(alu_res_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_st_data_i(rf_st_data_i),
    .memop_type_i(memop_type_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
    .memop_sign_ext_i(memop_sign_ext_i), .seq_new_pc_i(seq_new_pc_i),
    .is_jaljalr_i(is_jaljalr_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .stall_o(stall_o),
`ifdef SEGRE_MEM_MISALIGN_EN
    .misalign_o(misalign_o),
`endif
    .wb_valid_o(wb_valid_o), .wb_rf_we_o(wb_rf_we_o),
    .wb_rf_waddr_o(wb_rf_waddr_o), .wb_rf_wdata_o(wb_rf_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #50000;
    $display("FAIL timeout: observed no finish, expected finish before 50000");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs();
    valid_mem_i      = 1'b0;
    alu_res_i        = '0;
    rf_we_i          = 1'b0;
    rf_waddr_i       = '0;
    rf_st_data_i     = '0;
    memop_type_i     = T_WORD;
    memop_rd_i       = 1'b0;
    memop_wr_i       = 1'b0;
    memop_sign_ext_i = 1'b0;
    seq_new_pc_i     = '0;
    is_jaljalr_i     = 1'b0;
    dmem_gnt_i       = 1'b0;
    dmem_rvalid_i    = 1'b0;
    dmem_rdata_i     = '0;
  endtask

  initial begin
    rst_i = 1'b1;
    clear_inputs();
    #12;
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_be", dmem_be_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    chk("rst_wb_wdata", wb_rf_wdata_o, 0);
    rst_i = 1'b0;

    // ADD
    tick();
    valid_mem_i = 1; alu_res_i = 32'h1234; rf_we_i = 1; rf_waddr_i = 5;
    tick();
    clear_inputs();
    #1;
    chk("add_stall", stall_o, 0);
    chk("add_req", dmem_req_o, 0);
    tick();
    chk("add_wb_valid", wb_valid_o, 1);
    chk("add_wb_we", wb_rf_we_o, 1);
    chk("add_wb_waddr", wb_rf_waddr_o, 5);
    chk("add_wb_wdata", wb_rf_wdata_o, 32'h1234);

    // JAL
    valid_mem_i = 1; is_jaljalr_i = 1; seq_new_pc_i = 32'h2004; alu_res_i = 32'h55;
    rf_we_i = 1; rf_waddr_i = 1;
    tick();
    clear_inputs();
    tick();
    chk("jal_wb_wdata", wb_rf_wdata_o, 32'h2004);
    chk("jal_wb_valid", wb_valid_o, 1);
    tick();
    chk("bubble_wb_valid", wb_valid_o, 0);
    chk("bubble_wb_we", wb_rf_we_o, 0);

    // SW with grant two cycles late
    valid_mem_i = 1; memop_wr_i = 1; memop_type_i = T_WORD; alu_res_i = 32'h100;
    rf_st_data_i = 32'hDEADBEEF;
    tick();
    clear_inputs();
    #1;
    chk("sw_req", dmem_req_o, 1);
    chk("sw_we", dmem_we_o, 1);
    chk("sw_addr", dmem_addr_o, 32'h100);
    chk("sw_be", dmem_be_o, 4'b1111);
    chk("sw_wdata", dmem_wdata_o, 32'hDEADBEEF);
    chk("sw_stall", stall_o, 1);
    tick();
    chk("sw_hold1_req", dmem_req_o, 1);
    chk("sw_hold1_stall", stall_o, 1);
    chk("sw_hold1_wb_valid", wb_valid_o, 0);
    tick();
    chk("sw_hold2_req", dmem_req_o, 1);
    chk("sw_hold2_wdata", dmem_wdata_o, 32'hDEADBEEF);
    dmem_gnt_i = 1;
    #1;
    chk("sw_gnt_stall", stall_o, 0);
    chk("sw_gnt_req", dmem_req_o, 1);
    tick();
    dmem_gnt_i = 0;
    chk("sw_wb_valid", wb_valid_o, 1);
    chk("sw_wb_we", wb_rf_we_o, 0);
    chk("sw_after_req", dmem_req_o, 0);

    // LB sign-extended @0x103
    valid_mem_i = 1; memop_rd_i = 1; memop_type_i = T_BYTE; memop_sign_ext_i = 1;
    alu_res_i = 32'h103; rf_we_i = 1; rf_waddr_i = 7;
    tick();
    clear_inputs();
    dmem_gnt_i = 1;
    #1;
    chk("lb_req", dmem_req_o, 1);
    chk("lb_we", dmem_we_o, 0);
    chk("lb_addr", dmem_addr_o, 32'h100);
    chk("lb_be", dmem_be_o, 4'b1000);
    chk("lb_stall", stall_o, 1);
    tick();
    dmem_gnt_i = 0;
    chk("lb_wait_wb_valid", wb_valid_o, 0);
    #1;
    chk("lb_wait_req", dmem_req_o, 0);
    chk("lb_wait_stall", stall_o, 1);
    dmem_rvalid_i = 1; dmem_rdata_i = 32'h80123456;
    #1;
    chk("lb_rvalid_stall", stall_o, 0);
    tick();
    dmem_rvalid_i = 0;
    chk("lb_wb_valid", wb_valid_o, 1);
    chk("lb_wb_we", wb_rf_we_o, 1);
    chk("lb_wb_waddr", wb_rf_waddr_o, 7);
    chk("lb_wb_wdata", wb_rf_wdata_o, 32'hFFFFFF80);

    // LHU @0x102
    valid_mem_i = 1; memop_rd_i = 1; memop_type_i = T_HALF; alu_res_i = 32'h102;
    rf_we_i = 1; rf_waddr_i = 8;
    tick();
    clear_inputs();
    dmem_gnt_i = 1;
    #1;
    chk("lhu_be", dmem_be_o, 4'b1100);
    tick();
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'hBEEF0000;
    tick();
    dmem_rvalid_i = 0;
    chk("lhu_wb_wdata", wb_rf_wdata_o, 32'h0000BEEF);

    // SB 0xAB @0x101
    valid_mem_i = 1; memop_wr_i = 1; memop_type_i = T_BYTE; alu_res_i = 32'h101;
    rf_st_data_i = 32'h123456AB;
    tick();
    clear_inputs();
    dmem_gnt_i = 1;
    #1;
    chk("sb_be", dmem_be_o, 4'b0010);
    chk("sb_wdata", dmem_wdata_o, 32'hABABABAB);
    chk("sb_we", dmem_we_o, 1);
    tick();
    dmem_gnt_i = 0;
    chk("sb_wb_valid", wb_valid_o, 1);
    chk("sb_wb_we", wb_rf_we_o, 0);

    // Reset while a load waits for rvalid
    valid_mem_i = 1; memop_rd_i = 1; memop_type_i = T_WORD; alu_res_i = 32'h200;
    rf_we_i = 1; rf_waddr_i = 9;
    tick();
    clear_inputs();
    dmem_gnt_i = 1;
    tick();
    dmem_gnt_i = 0;
    #1;
    chk("rstw_pre_stall", stall_o, 1);
    rst_i = 1;
    #1;
    chk("rstw_stall", stall_o, 0);
    chk("rstw_req", dmem_req_o, 0);
    chk("rstw_wb_wdata", wb_rf_wdata_o, 0);
    chk("rstw_wb_waddr", wb_rf_waddr_o, 0);
    tick();
    rst_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h11111111;
    #1;
    chk("rstw_late_stall", stall_o, 0);
    tick();
    dmem_rvalid_i = 0;
    chk("rstw_late_wb_valid", wb_valid_o, 0);
    chk("rstw_late_wb_we", wb_rf_we_o, 0);
    chk("rstw_late_wb_wdata", wb_rf_wdata_o, 0);

`ifdef SEGRE_MEM_MISALIGN_EN
    // Misaligned LW @0x102 traps without a request
    valid_mem_i = 1; memop_rd_i = 1; memop_type_i = T_WORD; alu_res_i = 32'h102;
    rf_we_i = 1; rf_waddr_i = 3;
    tick();
    clear_inputs();
    #1;
    chk("mis_req", dmem_req_o, 0);
    chk("mis_stall", stall_o, 0);
    tick();
    chk("mis_flag", misalign_o, 1);
    chk("mis_wb_valid", wb_valid_o, 1);
    chk("mis_wb_we", wb_rf_we_o, 0);
    tick();
    chk("mis_flag_clear", misalign_o, 0);
`else
    // Misaligned LH @0x103 falls back to the upper half-word lanes
    valid_mem_i = 1; memop_rd_i = 1; memop_type_i = T_HALF; memop_sign_ext_i = 1;
    alu_res_i = 32'h103; rf_we_i = 1; rf_waddr_i = 3;
    tick();
    clear_inputs();
    dmem_gnt_i = 1;
    #1;
    chk("mis_req", dmem_req_o, 1);
    chk("mis_be", dmem_be_o, 4'b1100);
    tick();
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h80010000;
    tick();
    dmem_rvalid_i = 0;
    chk("mis_wb_wdata", wb_rf_wdata_o, 32'hFFFF8001);
    chk("mis_wb_we", wb_rf_we_o, 1);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
